// File: rtl/fp_add_sched_pkg.sv
// Shared types and constants for the FP32 adder scheduler.
// Optional feature macro used elsewhere in this slice: FP_ADD_SCHED_SUB_EN.
package fp_add_sched_pkg;

    localparam int FP_W      = 32;
    localparam int OPS_CNT_W = 16;

    typedef logic [FP_W-1:0] fp32_t;

    localparam fp32_t FP_QNAN = 32'h7FC0_0000;

    // Leading-zero count of a 27-bit datapath word (27 when the word is zero).
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       hit;
        n   = 5'd0;
        hit = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            n   = n + {4'd0, ~hit & ~v[i]};
            hit = hit | v[i];
        end
        return n;
    endfunction

endpackage

// File: rtl/flp_adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
// Subnormal inputs and results are flushed to signed zero.
module flp_adder
    import fp_add_sched_pkg::*;
(
    input  fp32_t a,
    input  fp32_t b,
    output fp32_t sum
);

    fp32_t             big_s, sml_s;
    logic [23:0]       big_m_s, sml_m_s;
    logic [7:0]        exp_diff_s;
    logic [5:0]        shamt_s;
    logic [49:0]       sml_sh_s;
    logic [26:0]       big_x_s, sml_x_s, norm_s;
    logic [27:0]       raw_s;
    logic [4:0]        lz_s;
    logic              eff_sub_s, rnd_up_s;
    logic signed [9:0] exp_s;
    logic [24:0]       mant_s;
    logic [22:0]       frac_s;
    logic              a_nan_s, b_nan_s, a_inf_s, b_inf_s;

    // Classify infinities and NaNs
    always_comb begin
        a_inf_s = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf_s = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan_s = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan_s = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    end

    // Align, add or subtract, normalise and round the finite path
    always_comb begin
        big_s      = (b[30:0] > a[30:0]) ? b : a;
        sml_s      = (b[30:0] > a[30:0]) ? a : b;
        big_m_s    = (big_s[30:23] != 8'd0) ? {1'b1, big_s[22:0]} : 24'd0;
        sml_m_s    = (sml_s[30:23] != 8'd0) ? {1'b1, sml_s[22:0]} : 24'd0;
        exp_diff_s = big_s[30:23] - sml_s[30:23];
        shamt_s    = (exp_diff_s > 8'd50) ? 6'd50 : exp_diff_s[5:0];
        // Small operand keeps guard, round and a sticky OR of everything below
        sml_sh_s   = {sml_m_s, 26'd0} >> shamt_s;
        sml_x_s    = {sml_sh_s[49:24], |sml_sh_s[23:0]};
        big_x_s    = {big_m_s, 3'd0};
        eff_sub_s  = big_s[31] ^ sml_s[31];
        raw_s      = eff_sub_s ? {1'b0, big_x_s - sml_x_s}
                               : ({1'b0, big_x_s} + {1'b0, sml_x_s});
        exp_s      = $signed({2'b00, big_s[30:23]});
        lz_s       = lzc27(raw_s[26:0]);
        if (raw_s[27]) begin
            norm_s = {raw_s[27:2], raw_s[1] | raw_s[0]};
            exp_s  = exp_s + 10'sd1;
        end else begin
            norm_s = raw_s[26:0] << lz_s;
            exp_s  = exp_s - $signed({5'd0, lz_s});
        end
        rnd_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        mant_s   = {1'b0, norm_s[26:3]} + {24'd0, rnd_up_s};
        if (mant_s[24]) begin
            frac_s = mant_s[23:1];
            exp_s  = exp_s + 10'sd1;
        end else begin
            frac_s = mant_s[22:0];
        end
    end

    // Choose between special-case results and the packed finite result
    always_comb begin
        if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (a[31] != b[31]))) begin
            sum = FP_QNAN;
        end else if (a_inf_s) begin
            sum = a;
        end else if (b_inf_s) begin
            sum = b;
        end else if (raw_s == 28'd0) begin
            sum = {big_s[31] & ~eff_sub_s, 31'd0};
        end else if (exp_s >= 10'sd255) begin
            sum = {big_s[31], 8'hFF, 23'd0};
        end else if (exp_s <= 10'sd0) begin
            sum = {big_s[31], 31'd0};
        end else begin
            sum = {big_s[31], exp_s[7:0], frac_s};
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr wins.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    // Scan requests starting at ptr, wrapping modulo N
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(ptr) + k) % N;
            if (en && !gnt_any && req[j]) begin
                gnt[j]  = 1'b1;
                gnt_idx = IDX_W'(j);
                gnt_any = 1'b1;
            end else begin
                gnt_any = gnt_any;
            end
        end
    end

endmodule

// File: rtl/fp_add_sched.sv
// Round-robin scheduler sharing one FP32 adder among N_REQ requesters.
// Define FP_ADD_SCHED_SUB_EN to add the per-requester req_sub (A-B) input.
module fp_add_sched
    import fp_add_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ-1:0][FP_W-1:0] req_a,
    input  logic [N_REQ-1:0][FP_W-1:0] req_b,
`ifdef FP_ADD_SCHED_SUB_EN
    input  logic [N_REQ-1:0]           req_sub,
`endif
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [ID_W-1:0]            resp_id,
    output fp32_t                      resp_sum,
    output logic [OPS_CNT_W-1:0]       ops_done
);

    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]      resp_id_q, resp_id_d;
    fp32_t                resp_sum_q, resp_sum_d;
    logic [OPS_CNT_W-1:0] ops_done_q, ops_done_d;

    logic                 slot_free_s, arb_en_s, consume_s;
    logic [N_REQ-1:0]     gnt_s;
    logic [ID_W-1:0]      gnt_idx_s;
    logic                 gnt_any_s;
    fp32_t                op_a_s, op_b_s, add_sum_s;

    // Grants are possible only when the response slot is empty or draining
    always_comb begin
        slot_free_s = !resp_valid_q || resp_ready;
        arb_en_s    = slot_free_s && !rst;
    end

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .en      (arb_en_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .gnt_any (gnt_any_s)
    );

    // Operand mux from the granted requester into the shared adder
    always_comb begin
        op_a_s = req_a[gnt_idx_s];
`ifdef FP_ADD_SCHED_SUB_EN
        op_b_s = req_sub[gnt_idx_s] ? {~req_b[gnt_idx_s][31], req_b[gnt_idx_s][30:0]}
                                    : req_b[gnt_idx_s];
`else
        op_b_s = req_b[gnt_idx_s];
`endif
    end

    flp_adder u_add (
        .a   (op_a_s),
        .b   (op_b_s),
        .sum (add_sum_s)
    );

    // Response register, round-robin pointer and consumed-response counter
    always_comb begin
        consume_s    = resp_valid_q && resp_ready;
        rr_ptr_d     = rr_ptr_q;
        resp_id_d    = resp_id_q;
        resp_sum_d   = resp_sum_q;
        resp_valid_d = resp_valid_q;
        if (gnt_any_s) begin
            resp_valid_d = 1'b1;
            resp_id_d    = gnt_idx_s;
            resp_sum_d   = add_sum_s;
            rr_ptr_d     = (gnt_idx_s == ID_W'(N_REQ - 1)) ? '0 : gnt_idx_s + ID_W'(1);
        end else if (consume_s) begin
            resp_valid_d = 1'b0;
        end else begin
            resp_valid_d = resp_valid_q;
        end
        ops_done_d = (consume_s && (ops_done_q != 16'hFFFF)) ? ops_done_q + 16'd1 : ops_done_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_sum_q   <= 32'h0;
            ops_done_q   <= 16'd0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_sum_q   <= resp_sum_d;
            ops_done_q   <= ops_done_d;
        end
    end

    assign req_ready  = gnt_s;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_sum   = resp_sum_q;
    assign ops_done   = ops_done_q;

endmodule
